// File: rtl/lsu_shift_pkg.sv
// Shared types and RV32I encoding constants for the load/store/shift controller.
package lsu_shift_pkg;

  localparam int DATA_W = 32;

  typedef enum logic [2:0] {
    IDLE,
    MEM_REQ,
    MEM_WAIT,
    SHIFT,
    DONE
  } state_e;

  typedef enum logic [1:0] {
    K_BAD,
    K_LW,
    K_SW,
    K_SHIFT
  } op_kind_e;

  typedef enum logic [1:0] {
    SH_SLL,
    SH_SRL,
    SH_SRA
  } shift_kind_e;

  localparam logic [6:0] LOAD   = 7'b0000011;
  localparam logic [6:0] STORE  = 7'b0100011;
  localparam logic [6:0] OP     = 7'b0110011;
  localparam logic [6:0] OP_IMM = 7'b0010011;

  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_SR  = 3'b101;
  localparam logic [2:0] F3_W   = 3'b010;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

endpackage

// File: rtl/lsu_shift_ctrl_if.sv
// Instruction, memory and writeback signals of the controller; slave is the controller side.
interface lsu_shift_ctrl_if;
  import lsu_shift_pkg::*;

  logic              valid_i;
  logic              ready_o;
  logic [DATA_W-1:0] instruction_i;
  logic [DATA_W-1:0] rs1_data_i;
  logic [DATA_W-1:0] rs2_data_i;
  logic              mem_req_o;
  logic              mem_we_o;
  logic [DATA_W-1:0] mem_addr_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_gnt_i;
  logic              mem_rvalid_i;
  logic [DATA_W-1:0] mem_rdata_i;
  logic              wb_valid_o;
  logic [4:0]        wb_rd_o;
  logic [DATA_W-1:0] wb_data_o;
  logic              done_o;
  logic              err_o;

  modport slave (
    input  valid_i, instruction_i, rs1_data_i, rs2_data_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    output wb_valid_o, wb_rd_o, wb_data_o, done_o, err_o
  );

  modport master (
    output valid_i, instruction_i, rs1_data_i, rs2_data_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  ready_o, mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o,
    input  wb_valid_o, wb_rd_o, wb_data_o, done_o, err_o
  );

endinterface

// File: rtl/lsu_shift_ctrl_decoder.sv
// Combinational decode of lw/sw/shift instructions: kind, shift type, amount, rd and effective address.
module decoder_load_store_shift
  import lsu_shift_pkg::*;
(
  input  logic [DATA_W-1:0] instruction_i,
  input  logic [DATA_W-1:0] rs1_data_i,
  input  logic [4:0]        rs2_shamt_i,
  output op_kind_e          kind_o,
  output shift_kind_e       shift_o,
  output logic [4:0]        shamt_o,
  output logic [4:0]        rd_o,
  output logic [DATA_W-1:0] addr_o,
  output logic              misaligned_o
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  logic signed [DATA_W-1:0] imm_i;
  logic signed [DATA_W-1:0] imm_s;
  logic unused_rs1_field;

  assign opcode = instruction_i[6:0];
  assign funct3 = instruction_i[14:12];
  assign funct7 = instruction_i[31:25];
  assign rd_o   = instruction_i[11:7];
  assign imm_i  = {{20{instruction_i[31]}}, instruction_i[31:20]};
  assign imm_s  = {{20{instruction_i[31]}}, instruction_i[31:25], instruction_i[11:7]};
  // Register indices are resolved upstream; only the operand values arrive here.
  assign unused_rs1_field = ^instruction_i[19:15];

  always_comb begin
    kind_o  = K_BAD;
    shift_o = SH_SLL;
    shamt_o = rs2_shamt_i;
    addr_o  = rs1_data_i + $unsigned(imm_i);
    case (opcode)
      LOAD: begin
        if (funct3 == F3_W) kind_o = K_LW;
      end
      STORE: begin
        addr_o = rs1_data_i + $unsigned(imm_s);
        if (funct3 == F3_W) kind_o = K_SW;
      end
      OP, OP_IMM: begin
        if (opcode == OP_IMM) shamt_o = instruction_i[24:20];
        if (funct3 == F3_SLL && funct7 == F7_BASE) begin
          kind_o  = K_SHIFT;
          shift_o = SH_SLL;
        end else if (funct3 == F3_SR && funct7 == F7_BASE) begin
          kind_o  = K_SHIFT;
          shift_o = SH_SRL;
        end else if (funct3 == F3_SR && funct7 == F7_ALT) begin
          kind_o  = K_SHIFT;
          shift_o = SH_SRA;
        end
      end
      default: kind_o = K_BAD;
    endcase
  end

  assign misaligned_o = (addr_o[1:0] != 2'b00);

endmodule

// File: rtl/lsu_shift_ctrl.sv
// Multi-cycle lw/sw/shift controller. Define FAST_SHIFT_EN for single-step barrel shifts;
// otherwise shifts iterate one bit per cycle in the SHIFT state.
module lsu_shift_ctrl
  import lsu_shift_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  lsu_shift_ctrl_if.slave  bus
);

  state_e            state_q, state_d;
  op_kind_e          dec_kind;
  shift_kind_e       dec_shift;
  logic [4:0]        dec_shamt;
  logic [4:0]        dec_rd;
  logic [DATA_W-1:0] dec_addr;
  logic              dec_mis;
  logic              accept;

  logic [DATA_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] result_q;
  logic [4:0]        rd_q;
  shift_kind_e       shift_q;
  logic              we_q;
  logic              is_load_q;
  logic              err_q;
  logic              wb_en_q;
`ifndef FAST_SHIFT_EN
  logic [4:0]        cnt_q;
`endif

  decoder_load_store_shift u_dec (
    .instruction_i (bus.instruction_i),
    .rs1_data_i    (bus.rs1_data_i),
    .rs2_shamt_i   (bus.rs2_data_i[4:0]),
    .kind_o        (dec_kind),
    .shift_o       (dec_shift),
    .shamt_o       (dec_shamt),
    .rd_o          (dec_rd),
    .addr_o        (dec_addr),
    .misaligned_o  (dec_mis)
  );

  assign accept = (state_q == IDLE) && bus.valid_i;

`ifdef FAST_SHIFT_EN
  function automatic logic [DATA_W-1:0] barrel_shift(input logic [DATA_W-1:0] v,
                                                     input shift_kind_e k,
                                                     input logic [4:0] s);
    logic signed [DATA_W-1:0] sv;
    sv = v;
    case (k)
      SH_SRL:  barrel_shift = v >> s;
      SH_SRA:  barrel_shift = sv >>> s;
      default: barrel_shift = v << s;
    endcase
  endfunction
`else
  function automatic logic [DATA_W-1:0] shift_step(input logic [DATA_W-1:0] v,
                                                   input shift_kind_e k);
    case (k)
      SH_SRL:  shift_step = {1'b0, v[DATA_W-1:1]};
      SH_SRA:  shift_step = {v[DATA_W-1], v[DATA_W-1:1]};
      default: shift_step = {v[DATA_W-2:0], 1'b0};
    endcase
  endfunction
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.valid_i) begin
          case (dec_kind)
            K_LW, K_SW: state_d = dec_mis ? DONE : MEM_REQ;
`ifdef FAST_SHIFT_EN
            K_SHIFT:    state_d = DONE;
`else
            K_SHIFT:    state_d = (dec_shamt == 5'd0) ? DONE : SHIFT;
`endif
            default:    state_d = DONE;
          endcase
        end
      end
      MEM_REQ: begin
        if (bus.mem_gnt_i) state_d = is_load_q ? MEM_WAIT : DONE;
      end
      MEM_WAIT: begin
        if (bus.mem_rvalid_i) state_d = DONE;
      end
      SHIFT: begin
`ifdef FAST_SHIFT_EN
        state_d = DONE;
`else
        if (cnt_q == 5'd1) state_d = DONE;
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operands are latched at accept; the result register is reused for shift and load data.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      addr_q    <= '0;
      wdata_q   <= '0;
      result_q  <= '0;
      rd_q      <= '0;
      shift_q   <= SH_SLL;
      we_q      <= 1'b0;
      is_load_q <= 1'b0;
      err_q     <= 1'b0;
      wb_en_q   <= 1'b0;
`ifndef FAST_SHIFT_EN
      cnt_q     <= '0;
`endif
    end else if (accept) begin
      addr_q    <= dec_addr;
      wdata_q   <= bus.rs2_data_i;
      rd_q      <= dec_rd;
      shift_q   <= dec_shift;
      we_q      <= (dec_kind == K_SW);
      is_load_q <= (dec_kind == K_LW);
      err_q     <= (dec_kind == K_LW || dec_kind == K_SW) && dec_mis;
      wb_en_q   <= (dec_rd != 5'd0) &&
                   ((dec_kind == K_LW && !dec_mis) || dec_kind == K_SHIFT);
`ifdef FAST_SHIFT_EN
      result_q  <= barrel_shift(bus.rs1_data_i, dec_shift, dec_shamt);
`else
      result_q  <= bus.rs1_data_i;
      cnt_q     <= dec_shamt;
`endif
    end else if (state_q == MEM_WAIT && bus.mem_rvalid_i) begin
      result_q <= bus.mem_rdata_i;
    end
`ifndef FAST_SHIFT_EN
    else if (state_q == SHIFT) begin
      result_q <= shift_step(result_q, shift_q);
      cnt_q    <= cnt_q - 5'd1;
    end
`endif
  end

  // Outputs are decoded from state so reset clears them without waiting for a clock.
  assign bus.ready_o     = (state_q == IDLE);
  assign bus.mem_req_o   = (state_q == MEM_REQ);
  assign bus.mem_we_o    = bus.mem_req_o && we_q;
  assign bus.mem_addr_o  = bus.mem_req_o ? addr_q : '0;
  assign bus.mem_wdata_o = bus.mem_req_o ? wdata_q : '0;
  assign bus.done_o      = (state_q == DONE);
  assign bus.err_o       = bus.done_o && err_q;
  assign bus.wb_valid_o  = bus.done_o && wb_en_q;
  assign bus.wb_rd_o     = bus.wb_valid_o ? rd_q : '0;
  assign bus.wb_data_o   = bus.wb_valid_o ? result_q : '0;

endmodule

// File: tb/tb_lsu_shift_ctrl.sv
// Directed bench for lsu_shift_ctrl: shifts, lw/sw handshakes, misalignment, bad opcode, reset mid-load.
module tb_lsu_shift_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_err = 0;
  int   lat;

  lsu_shift_ctrl_if bus();

  lsu_shift_ctrl dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] r_enc(input logic [6:0] f7, input logic [4:0] rs2f,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] opc);
    return {f7, rs2f, 5'd1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] s_enc(input logic [11:0] imm, input logic [2:0] f3);
    return {imm[11:5], 5'd2, 5'd1, f3, imm[4:0], 7'b0100011};
  endfunction

  function automatic int exp_lat(input int shamt);
`ifdef FAST_SHIFT_EN
    return 1;
`else
    return shamt + 1;
`endif
  endfunction

  // Called on a falling edge; returns on the falling edge of the first cycle after accept.
  task automatic issue(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b);
    chk("ready_before_issue", {31'd0, bus.ready_o}, 32'd1);
    bus.valid_i       = 1'b1;
    bus.instruction_i = ins;
    bus.rs1_data_i    = a;
    bus.rs2_data_i    = b;
    @(negedge clk);
    bus.valid_i = 1'b0;
  endtask

  task automatic wait_done(output int l);
    l = 1;
    while (!bus.done_o && l < 100) begin
      @(negedge clk);
      l++;
    end
  endtask

  task automatic shift_case(input string tag, input logic [31:0] ins, input logic [31:0] a,
                            input logic [31:0] b, input int shamt, input logic [4:0] rd,
                            input logic [31:0] exp);
    int l;
    issue(ins, a, b);
    wait_done(l);
    chk({tag, "_lat"}, l, exp_lat(shamt));
    chk({tag, "_wbv"}, {31'd0, bus.wb_valid_o}, {31'd0, rd != 5'd0});
    chk({tag, "_rd"}, {27'd0, bus.wb_rd_o}, (rd != 5'd0) ? {27'd0, rd} : 32'd0);
    chk({tag, "_data"}, bus.wb_data_o, (rd != 5'd0) ? exp : 32'd0);
    chk({tag, "_err"}, {31'd0, bus.err_o}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    bus.valid_i       = 1'b0;
    bus.instruction_i = '0;
    bus.rs1_data_i    = '0;
    bus.rs2_data_i    = '0;
    bus.mem_gnt_i     = 1'b0;
    bus.mem_rvalid_i  = 1'b0;
    bus.mem_rdata_i   = '0;

    repeat (2) @(negedge clk);
    chk("rst_ready", {31'd0, bus.ready_o}, 32'd1);
    chk("rst_req", {31'd0, bus.mem_req_o}, 32'd0);
    chk("rst_done", {31'd0, bus.done_o}, 32'd0);
    chk("rst_wbv", {31'd0, bus.wb_valid_o}, 32'd0);
    chk("rst_err", {31'd0, bus.err_o}, 32'd0);
    chk("rst_addr", bus.mem_addr_o, 32'd0);
    chk("rst_wbdata", bus.wb_data_o, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // slli x5, x1, 4
    shift_case("slli", r_enc(7'b0000000, 5'd4, 3'b001, 5'd5, 7'b0010011),
               32'h0000_000F, 32'h0, 4, 5'd5, 32'h0000_00F0);
    chk("slli_back_idle", {31'd0, bus.ready_o}, 32'd1);
    chk("slli_done_pulse", {31'd0, bus.done_o}, 32'd0);
    // srai/srli by 31
    shift_case("srai", r_enc(7'b0100000, 5'd31, 3'b101, 5'd6, 7'b0010011),
               32'h8000_0000, 32'h0, 31, 5'd6, 32'hFFFF_FFFF);
    shift_case("srli", r_enc(7'b0000000, 5'd31, 3'b101, 5'd6, 7'b0010011),
               32'h8000_0000, 32'h0, 31, 5'd6, 32'h0000_0001);
    // register shifts: amount from rs2[4:0], upper rs2 bits ignored
    shift_case("sll", r_enc(7'b0000000, 5'd9, 3'b001, 5'd7, 7'b0110011),
               32'h8100_0001, 32'h0000_0023, 3, 5'd7, 32'h0800_0008);
    shift_case("sra", r_enc(7'b0100000, 5'd9, 3'b101, 5'd8, 7'b0110011),
               32'h8000_0010, 32'h0000_0004, 4, 5'd8, 32'hF800_0001);
    shift_case("sll_rd0", r_enc(7'b0000000, 5'd9, 3'b001, 5'd0, 7'b0110011),
               32'h1234_5678, 32'h0000_0000, 0, 5'd0, 32'h0);

    // lw x9, 8(x1): grant after 2 cycles, rvalid 3 cycles into MEM_WAIT
    issue({12'd8, 5'd1, 3'b010, 5'd9, 7'b0000011}, 32'h100, 32'h0);
    lat = 1;
    for (int i = 0; i < 3; i++) begin
      chk("lw_req", {31'd0, bus.mem_req_o}, 32'd1);
      chk("lw_addr", bus.mem_addr_o, 32'h108);
      chk("lw_we", {31'd0, bus.mem_we_o}, 32'd0);
      if (i == 2) bus.mem_gnt_i = 1'b1;
      @(negedge clk);
      lat++;
    end
    bus.mem_gnt_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("lw_wait_req", {31'd0, bus.mem_req_o}, 32'd0);
      chk("lw_wait_done", {31'd0, bus.done_o}, 32'd0);
      @(negedge clk);
      lat++;
    end
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'hDEAD_BEEF;
    @(negedge clk);
    lat++;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i  = '0;
    chk("lw_done", {31'd0, bus.done_o}, 32'd1);
    chk("lw_lat", lat, 8);
    chk("lw_wbv", {31'd0, bus.wb_valid_o}, 32'd1);
    chk("lw_rd", {27'd0, bus.wb_rd_o}, 32'd9);
    chk("lw_data", bus.wb_data_o, 32'hDEAD_BEEF);
    @(negedge clk);

    // sw x2, -4(x1): immediate grant
    issue(s_enc(12'hFFC, 3'b010), 32'h200, 32'h1234_5678);
    chk("sw_req", {31'd0, bus.mem_req_o}, 32'd1);
    chk("sw_we", {31'd0, bus.mem_we_o}, 32'd1);
    chk("sw_addr", bus.mem_addr_o, 32'h1FC);
    chk("sw_wdata", bus.mem_wdata_o, 32'h1234_5678);
    bus.mem_gnt_i = 1'b1;
    @(negedge clk);
    bus.mem_gnt_i = 1'b0;
    chk("sw_done", {31'd0, bus.done_o}, 32'd1);
    chk("sw_wbv", {31'd0, bus.wb_valid_o}, 32'd0);
    chk("sw_err", {31'd0, bus.err_o}, 32'd0);
    @(negedge clk);

    // misaligned sw at 0x102
    issue(s_enc(12'h000, 3'b010), 32'h102, 32'hAAAA_5555);
    chk("mis_done", {31'd0, bus.done_o}, 32'd1);
    chk("mis_err", {31'd0, bus.err_o}, 32'd1);
    chk("mis_req", {31'd0, bus.mem_req_o}, 32'd0);
    chk("mis_wbv", {31'd0, bus.wb_valid_o}, 32'd0);
    @(negedge clk);
    chk("mis_err_pulse", {31'd0, bus.err_o}, 32'd0);

    // add x3, x1, x2 is unsupported
    issue(r_enc(7'b0000000, 5'd2, 3'b000, 5'd3, 7'b0110011), 32'h5, 32'h6);
    chk("bad_done", {31'd0, bus.done_o}, 32'd1);
    chk("bad_err", {31'd0, bus.err_o}, 32'd0);
    chk("bad_wbv", {31'd0, bus.wb_valid_o}, 32'd0);
    @(negedge clk);

    // reset asserted while waiting for load data
    issue({12'd0, 5'd1, 3'b010, 5'd4, 7'b0000011}, 32'h40, 32'h0);
    bus.mem_gnt_i = 1'b1;
    @(negedge clk);
    bus.mem_gnt_i = 1'b0;
    chk("rstw_in_wait", {31'd0, bus.mem_req_o | bus.ready_o}, 32'd0);
    #2 rst_n = 1'b0;
    #1;
    chk("rstw_ready", {31'd0, bus.ready_o}, 32'd1);
    chk("rstw_req", {31'd0, bus.mem_req_o}, 32'd0);
    chk("rstw_done", {31'd0, bus.done_o}, 32'd0);
    chk("rstw_wbv", {31'd0, bus.wb_valid_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 32'hCAFE_F00D;
    @(negedge clk);
    bus.mem_rvalid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rstw_late_done", {31'd0, bus.done_o}, 32'd0);
      chk("rstw_late_wbv", {31'd0, bus.wb_valid_o}, 32'd0);
      chk("rstw_late_ready", {31'd0, bus.ready_o}, 32'd1);
      @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout obs=running exp=finished");
    $fatal(1);
  end

endmodule
